// File: rtl/instruction_fetch_stage_if.sv
// ============================================================================
// instruction_fetch_stage_if : load port and fetch outputs of the IF stage
// Rev 1.0
// ============================================================================
`default_nettype none

interface instruction_fetch_stage_if #(
    parameter int CNT_W = 16
) ();
    logic             load_en;
    logic [5:0]       load_addr;
    logic [7:0]       load_data;
    logic             start;
    logic [7:0]       Instruction_Codep;
    logic [5:0]       PC;
    logic             running;
    logic             halted;
    logic [CNT_W-1:0] fetch_count;

    modport master (
        output load_en, load_addr, load_data, start,
        input  Instruction_Codep, PC, running, halted, fetch_count
    );

    modport slave (
        input  load_en, load_addr, load_data, start,
        output Instruction_Codep, PC, running, halted, fetch_count
    );
endinterface

`default_nettype wire

// File: rtl/instruction_fetch_stage.sv
// ============================================================================
// instruction_fetch_stage : 64x8 instruction memory, PC and LOAD/RUN/HALT control
// Rev 1.0
// ============================================================================
`default_nettype none

module instruction_fetch_stage #(
    parameter int          CNT_W  = 16,
    parameter logic [1:0]  JMP_OP = 2'b11
) (
    input  wire logic               clk,
    input  wire logic               reset,
    instruction_fetch_stage_if.slave bus
);

    localparam logic [1:0] S_LOAD = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [5:0]       r_pc;
    logic [5:0]       w_pc_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [7:0]       r_mem [0:63];

    logic [7:0]       w_fetch;
    logic             w_is_jmp;
    logic             w_self_jmp;
    logic             w_mem_we;

    // Raw memory read at the PC; gated to zero outside RUN on the output.
    assign w_fetch    = r_mem[r_pc];
    assign w_is_jmp   = (w_fetch[7:6] == JMP_OP);
    assign w_self_jmp = w_is_jmp && (w_fetch[5:0] == r_pc);
    assign w_mem_we   = (r_state == S_LOAD) && bus.load_en;

    // Memory has no reset so a loaded program survives reset and HALT.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[bus.load_addr] <= bus.load_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_LOAD;
            r_pc    <= 6'd0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_LOAD: begin
                w_pc_nxt = 6'd0;
                // A write in the same cycle takes priority over start.
                if (bus.start && !bus.load_en) begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = '0;
                end
            end
            S_RUN: begin
                if (r_cnt != C_CNT_MAX) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
                if (w_self_jmp) begin
                    w_state_nxt = S_HALT;
                end else if (w_is_jmp) begin
                    w_pc_nxt = w_fetch[5:0];
                end else begin
                    w_pc_nxt = r_pc + 6'd1;
                end
            end
            S_HALT: begin
                if (bus.start) begin
                    w_state_nxt = S_LOAD;
                    w_pc_nxt    = 6'd0;
                end
            end
            default: begin
                w_state_nxt = S_LOAD;
                w_pc_nxt    = 6'd0;
            end
        endcase
    end

    always_comb begin
        bus.running           = (r_state == S_RUN);
        bus.halted            = (r_state == S_HALT);
        bus.Instruction_Codep = 8'h00;
        if (r_state == S_RUN) begin
            bus.Instruction_Codep = w_fetch;
        end
    end

    assign bus.PC          = r_pc;
    assign bus.fetch_count = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch_stage.sv
// ============================================================================
// tb_instruction_fetch_stage : directed + random checks against a fetch model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_instruction_fetch_stage;

    localparam int CNT_W   = 5;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    instruction_fetch_stage_if #(.CNT_W(CNT_W)) bus ();

    instruction_fetch_stage #(
        .CNT_W (CNT_W),
        .JMP_OP(2'b11)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Reference model: program image, mode flags, PC and fetch counter.
    int m_mem [64];
    bit m_run;
    bit m_halt;
    int m_pc;
    int m_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_instr();
        return m_run ? m_mem[m_pc] : 0;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".instr"},   {24'd0, bus.Instruction_Codep}, exp_instr());
        chk({tag, ".pc"},      {26'd0, bus.PC},                m_pc);
        chk({tag, ".running"}, {31'd0, bus.running},           {31'd0, m_run});
        chk({tag, ".halted"},  {31'd0, bus.halted},            {31'd0, m_halt});
        chk({tag, ".count"},   {{(32-CNT_W){1'b0}}, bus.fetch_count}, m_cnt);
    endtask

    task automatic model_reset();
        m_run  = 0;
        m_halt = 0;
        m_pc   = 0;
        m_cnt  = 0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        int ins;
        if (m_run) begin
            ins   = m_mem[m_pc];
            m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : m_cnt;
            if (ins / 64 == 3) begin
                if (ins % 64 == m_pc) begin
                    m_run  = 0;
                    m_halt = 1;
                end else begin
                    m_pc = ins % 64;
                end
            end else begin
                m_pc = (m_pc + 1) % 64;
            end
        end else if (m_halt) begin
            if (bus.start) begin
                m_halt = 0;
                m_pc   = 0;
            end
        end else begin
            if (bus.load_en) begin
                m_mem[bus.load_addr] = bus.load_data;
            end else if (bus.start) begin
                m_run = 1;
                m_cnt = 0;
            end
        end
    endtask

    task automatic cycle(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic load(input int a, input int d);
        bus.load_en   = 1'b1;
        bus.load_addr = a[5:0];
        bus.load_data = d[7:0];
        cycle("load");
        bus.load_en   = 1'b0;
    endtask

    task automatic pulse_start(input string tag);
        bus.start = 1'b1;
        cycle(tag);
        bus.start = 1'b0;
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic reset_pulse();
        #3;
        reset = 1'b0;
        #1;
        model_reset();
        check_all("rst_async");
        #1;
        reset = 1'b1;
    endtask

    initial begin
        bus.load_en   = 1'b0;
        bus.load_addr = 6'd0;
        bus.load_data = 8'd0;
        bus.start     = 1'b0;
        for (int i = 0; i < 64; i++) m_mem[i] = 0;
        model_reset();

        #2;
        check_all("por");
        #10;
        reset = 1'b1;

        for (int i = 0; i < 64; i++) load(i, i);

        // Sequential fetch
        load(0, 'h11); load(1, 'h22); load(2, 'h33); load(3, 'h44);
        pulse_start("seq");
        chk("seq.first", {24'd0, bus.Instruction_Codep}, 32'h11);
        repeat (4) cycle("seq");
        chk("seq.cnt4", {{(32-CNT_W){1'b0}}, bus.fetch_count}, 32'd4);
        reset_pulse();

        // Forward jump skips address 3
        load(2, 'hC8); load(8, 'h5A);
        pulse_start("fwd");
        repeat (2) cycle("fwd");
        chk("fwd.jmp", {24'd0, bus.Instruction_Codep}, 32'hC8);
        cycle("fwd");
        chk("fwd.pc8", {26'd0, bus.PC}, 32'd8);
        chk("fwd.tgt", {24'd0, bus.Instruction_Codep}, 32'h5A);
        reset_pulse();

        // Wrap 62 -> 63 -> 0
        load(1, 'hFE); load(62, 'h01); load(63, 'h02); load(0, 'h03);
        pulse_start("wrap");
        repeat (3) cycle("wrap");
        chk("wrap.63", {26'd0, bus.PC}, 32'd63);
        cycle("wrap");
        chk("wrap.pc0", {26'd0, bus.PC}, 32'd0);
        chk("wrap.ins", {24'd0, bus.Instruction_Codep}, 32'h03);
        reset_pulse();

        // Halt on jump-to-self
        load(0, 'h11); load(1, 'h10); load(2, 'h20); load(5, 'hC5);
        pulse_start("halt");
        repeat (6) cycle("halt");
        chk("halt.flag", {31'd0, bus.halted}, 32'd1);
        chk("halt.pc5",  {26'd0, bus.PC}, 32'd5);
        repeat (3) cycle("halt.hold");
        pulse_start("halt.exit");
        chk("halt.exit.pc", {26'd0, bus.PC}, 32'd0);

        // start together with load_en in LOAD: write lands, stays in LOAD
        bus.start = 1'b1;
        load(9, 'h77);
        bus.start = 1'b0;
        chk("ignB.run", {31'd0, bus.running}, 32'd0);
        load(0, 'hC9);
        pulse_start("ignB");
        cycle("ignB");
        chk("ignB.data", {24'd0, bus.Instruction_Codep}, 32'h77);

        // load_en during RUN is ignored
        bus.load_en = 1'b1; bus.load_addr = 6'd0; bus.load_data = 8'hFF;
        repeat (3) cycle("ignA");
        bus.load_en = 1'b0;
        reset_pulse();
        pulse_start("ignA.rerun");
        chk("ignA.mem0", {24'd0, bus.Instruction_Codep}, 32'hC9);

        // Reset mid-run at PC=3, then rerun from 0
        reset_pulse();
        load(0, 'h11); load(1, 'h10); load(2, 'h20);
        pulse_start("mid");
        repeat (3) cycle("mid");
        chk("mid.pc3", {26'd0, bus.PC}, 32'd3);
        reset_pulse();
        pulse_start("mid.rerun");
        chk("mid.mem0", {24'd0, bus.Instruction_Codep}, 32'h11);

        // Counter saturation on a two-instruction loop
        reset_pulse();
        load(0, 'hC1); load(1, 'hC0);
        pulse_start("sat");
        repeat (40) cycle("sat");
        chk("sat.max", {{(32-CNT_W){1'b0}}, bus.fetch_count}, CNT_MAX);

        // Random programs and command noise
        reset_pulse();
        for (int i = 0; i < 64; i++) load(i, int'($urandom_range(0, 255)));
        repeat (400) begin
            bus.start     = ($urandom_range(0, 7) == 0);
            bus.load_en   = $urandom_range(0, 1) == 1;
            bus.load_addr = 6'($urandom_range(0, 63));
            bus.load_data = 8'($urandom_range(0, 255));
            cycle("rnd");
            if ($urandom_range(0, 49) == 0) reset_pulse();
        end
        bus.start   = 1'b0;
        bus.load_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/instruction_fetch_stage.md
# instruction_fetch_stage

- Front end of the rudimentary pipelined processor; sits directly upstream of the IF/ID pipeline register.
- Holds a 64-entry × 8-bit instruction memory, loaded through a write port, and a 6-bit program counter.
- Presents the instruction at the current PC on Instruction_Codep, which IF/ID samples.
- Resolves jumps (opcode [7:6]=2'b11) in the fetch cycle. IF/ID flushes the fetched jump, so jumps cost one bubble and no extra PC penalty.

## Interface
- CNT_W, 16, width of the fetch counter (saturating).
- JMP_OP, 2'b11, opcode in bits [7:6] that marks a jump; bits [5:0] are the absolute target.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low; reset==0 clears all state except memory contents.
- load_en  input  1  memory write strobe; honoured only in LOAD.
- load_addr  input  6  memory write address.
- load_data  input  8  memory write data.
- start  input  1  single-cycle pulse; LOAD→RUN or HALT→LOAD.
- Instruction_Codep  output  8  fetched instruction to IF/ID; 8'h00 outside RUN.
- PC  output  6  current program counter.
- running  output  1  high in RUN.
- halted  output  1  high in HALT.
- fetch_count  output  CNT_W  instructions presented in the current run.

## Operation
- States: LOAD (reset state), RUN, HALT; 2-bit state register.
- LOAD:
  - PC held at 0; Instruction_Codep=0.
  - load_en=1 writes load_data to mem[load_addr] at the clock edge.
  - start=1 with load_en=0 → RUN at the next edge.
  - start=1 with load_en=1 → the write is performed, start is ignored, state remains LOAD.
- RUN:
  - Instruction_Codep = mem[PC], combinational read.
  - Next PC:
    - If Instruction_Codep[7:6]==JMP_OP, next PC = Instruction_Codep[5:0].
    - Otherwise next PC = PC+1, mod 64; 63 wraps to 0.
  - load_en and start are ignored.
- Jump-to-self (jump whose target == PC) in RUN → HALT at the next edge; PC is not changed.
- HALT:
  - Instruction_Codep=0; PC frozen at the halting address.
  - start=1 → LOAD at the next edge, with PC=0.
  - load_en is ignored.
- fetch_count:
  - Cleared on reset and on the LOAD→RUN edge.
  - +1 at every edge that ends a RUN cycle, including the halting jump.
  - Saturates at all-ones; no wrap.
- Memory:
  - No reset; contents survive reset and HALT.
  - Reads of never-written locations return unknown; the bench must load before use.
- Outputs from state:
  - running = (state==RUN).
  - halted = (state==HALT).

## Timing
- Reset (async assert):
  - state=LOAD, PC=0, fetch_count=0, running=0, halted=0, Instruction_Codep=0.
  - Deassertion is synchronous to clk via the normal flop path; the first accepted command is at the first rising edge with reset=1.
- Load write: data visible to reads in the cycle after the write edge.
- start latency: start sampled at edge k → running=1 and Instruction_Codep=mem[0] immediately after edge k.
- Fetch throughput: one instruction per cycle, no stalls. PC→Instruction_Codep is combinational within the cycle.
- Jump:
  - Jump presented in cycle n; target instruction presented in cycle n+1.
  - IF/ID captures 0 for cycle n, as it flushes opcode 11.
- Halt: halting jump presented in cycle n; halted=1 and Instruction_Codep=0 from cycle n+1.
- Reset mid-RUN or mid-HALT: immediate return to LOAD values listed above. Memory is unchanged, so start alone reruns the program.

## Test plan
- Sequential fetch:
  - Stimulus: load mem[0..3]=8'h11,8'h22,8'h33,8'h44; pulse start.
  - Required: Instruction_Codep = 11,22,33,44 on consecutive cycles; PC=0..3; fetch_count=4 after the 4th edge.
- Forward jump:
  - Stimulus: mem[2]=8'hC8 (jump to 8), mem[8]=8'h5A.
  - Required: cycle presenting C8 is followed directly by 5A; PC goes 2→8; no instruction from address 3 is presented.
- Wrap:
  - Stimulus: fill mem[62]=8'h01, mem[63]=8'h02, mem[0]=8'h03; reach PC=62.
  - Required: PC sequence 62,63,0; outputs 01,02,03.
- Halt on jump-to-self:
  - Stimulus: mem[5]=8'hC5.
  - Required: halted=1 and running=0 after the edge ending that cycle; PC stays 5; Instruction_Codep=0 thereafter.
  - Follow-up: pulse start → LOAD, PC=0.
- Ignored commands:
  - Stimulus A: load_en=1 with addr 0, data 8'hFF during RUN. Required: mem[0] unchanged after reset+start.
  - Stimulus B: start and load_en together in LOAD. Required: write lands, state stays LOAD.
- Reset mid-run:
  - Stimulus: assert reset between edges while PC=3.
  - Required: outputs drop to LOAD values at once without a clock edge; after release and start, mem[0] is fetched again.
